// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its accumulator controller:
// opcodes, controller FSM encoding and flag-word bit positions.
package alu_pkg;

    localparam logic [3:0] OP_INVALID   = 4'd0;
    localparam logic [3:0] OP_ADD       = 4'd1;
    localparam logic [3:0] OP_ADD_CARRY = 4'd2;
    localparam logic [3:0] OP_SUB       = 4'd3;
    localparam logic [3:0] OP_INC       = 4'd4;
    localparam logic [3:0] OP_DEC       = 4'd5;
    localparam logic [3:0] OP_AND       = 4'd6;
    localparam logic [3:0] OP_NOT       = 4'd7;
    localparam logic [3:0] OP_ROL       = 4'd8;
    localparam logic [3:0] OP_ROR       = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } ctrl_state_e;

    localparam int FLAG_CARRY   = 0;
    localparam int FLAG_BORROW  = 1;
    localparam int FLAG_ZERO    = 2;
    localparam int FLAG_PARITY  = 3;
    localparam int FLAG_INVALID = 4;
    localparam int FLAG_W       = 5;

    function automatic logic [FLAG_W-1:0] pack_flags(
        input logic carry,
        input logic borrow,
        input logic zero,
        input logic parity,
        input logic invalid
    );
        logic [FLAG_W-1:0] f;
        f               = 5'b00000;
        f[FLAG_CARRY]   = carry;
        f[FLAG_BORROW]  = borrow;
        f[FLAG_ZERO]    = zero;
        f[FLAG_PARITY]  = parity;
        f[FLAG_INVALID] = invalid;
        return f;
    endfunction

endpackage

// File: rtl/alu_ctrl.sv
// Accumulator sequencer driving a combinational ALU, one instruction in flight.
// Optional ALU_CTRL_ERR_CNT_EN adds a saturating invalid-opcode counter (err_count).
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_load,
    input  logic [3:0]           in_opcode,
    input  logic [BUS_WIDTH-1:0] in_operand,
    output logic [BUS_WIDTH-1:0] alu_a,
    output logic [BUS_WIDTH-1:0] alu_b,
    output logic                 alu_carry_in,
    output logic [3:0]           alu_opcode,
    input  logic [BUS_WIDTH-1:0] alu_y,
    input  logic                 alu_carry_out,
    input  logic                 alu_borrow,
    input  logic                 alu_zero,
    input  logic                 alu_parity,
    input  logic                 alu_invalid_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out_result,
    output logic [FLAG_W-1:0]    out_flags
`ifdef ALU_CTRL_ERR_CNT_EN
    ,
    output logic [7:0]           err_count
`endif
);

    ctrl_state_e           state_r, state_next_s;
    logic                  in_ready_r, out_valid_r;
    logic                  accept_s;
    logic                  load_r;
    logic [BUS_WIDTH-1:0]  acc_r, alu_a_r, alu_b_r;
    logic                  carry_r, alu_carry_in_r;
    logic [3:0]            alu_opcode_r;
    logic [FLAG_W-1:0]     flags_r, alu_flags_s;

    // Next-state decode and ALU flag packing
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        alu_flags_s  = pack_flags(alu_carry_out, alu_borrow, alu_zero,
                                  alu_parity, alu_invalid_op);
        case (state_r)
            ST_IDLE: begin
                // in_ready_r gates acceptance so nothing is taken in the cycle after reset
                if (in_valid && in_ready_r) begin
                    state_next_s = ST_EXEC;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: state_next_s = ST_RESP;
            ST_RESP: begin
                if (out_valid_r && out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == ST_IDLE);
            out_valid_r <= (state_next_s == ST_RESP);
        end
    end

    // Operand registers: loaded on accept, held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            load_r         <= 1'b0;
            alu_a_r        <= {BUS_WIDTH{1'b0}};
            alu_b_r        <= {BUS_WIDTH{1'b0}};
            alu_carry_in_r <= 1'b0;
            alu_opcode_r   <= 4'd0;
        end else if (accept_s) begin
            load_r         <= in_load;
            alu_a_r        <= acc_r;
            alu_b_r        <= in_operand;
            alu_carry_in_r <= carry_r;
            alu_opcode_r   <= in_opcode;
        end
    end

    // Accumulator, carry and flag capture at the end of EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r   <= {BUS_WIDTH{1'b0}};
            carry_r <= 1'b0;
            flags_r <= 5'b00000;
        end else if (state_r == ST_EXEC) begin
            if (load_r) begin
                acc_r   <= alu_b_r;
                carry_r <= 1'b0;
                flags_r <= 5'b00000;
            end else if (!alu_invalid_op) begin
                acc_r   <= alu_y;
                carry_r <= alu_carry_out;
                flags_r <= alu_flags_s;
            end else begin
                flags_r <= alu_flags_s;
            end
        end
    end

`ifdef ALU_CTRL_ERR_CNT_EN
    logic [7:0] err_count_r;

    // Saturating count of invalid opcodes executed
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_r <= 8'd0;
        end else if ((state_r == ST_EXEC) && !load_r && alu_invalid_op
                     && (err_count_r != 8'd255)) begin
            err_count_r <= err_count_r + 8'd1;
        end
    end

    assign err_count = err_count_r;
`endif

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign out_result   = acc_r;
    assign out_flags    = flags_r;
    assign alu_a        = alu_a_r;
    assign alu_b        = alu_b_r;
    assign alu_carry_in = alu_carry_in_r;
    assign alu_opcode   = alu_opcode_r;

endmodule
